program_counter: RTL and testbench



---
 rtl/program_counter.sv | 147 ++++++++++++++
 tb/tb_program_counter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/program_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | program_counter: PC sequencing, branch/jump resolution and trap redirect |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module program_counter #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR  = ADDR_WIDTH'('h10),
  parameter bit                    COMPRESSED   = 1'b0,
  parameter int                    WAIT_CYCLES  = 1,
  parameter int                    COUNT_WIDTH  = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_WIDTH-1:0]  i_lhs,
  input  logic [DATA_WIDTH-1:0]  i_rhs,
  input  logic [2:0]             i_operation,
  input  logic [ADDR_WIDTH-1:0]  i_immediate_offset,
  input  logic [ADDR_WIDTH-1:0]  i_register_address,
  input  logic                   i_branch,
  input  logic                   i_immediate_jump,
  input  logic                   i_register_jump,
  input  logic                   i_instr_16,
  input  logic                   i_advance,
  output logic [ADDR_WIDTH-1:0]  o_program_count,
  output logic [ADDR_WIDTH-1:0]  o_next_instruction,
  output logic                   o_fetch_valid,
  output logic                   o_redirect,
  output logic                   o_fault,
  output logic [ADDR_WIDTH-1:0]  o_epc,
  output logic [1:0]             o_cause,
  output logic [COUNT_WIDTH-1:0] o_instret
);

  localparam logic [3:0] c_WAIT_INIT    = 4'(WAIT_CYCLES);
  localparam logic [1:0] c_CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] c_CAUSE_MISALIGN = 2'd2;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_RUN  = 2'd1,
    S_TRAP = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [3:0]              r_wait_cnt;
  logic [ADDR_WIDTH-1:0]   r_pc;
  logic [ADDR_WIDTH-1:0]   r_epc;
  logic [1:0]              r_cause;
  logic [COUNT_WIDTH-1:0]  r_instret;

  logic                    w_run;
  logic                    w_cond;
  logic                    w_illegal;
  logic                    w_transfer;
  logic                    w_misaligned;
  logic                    w_fault;
  logic [1:0]              w_cause;
  logic [ADDR_WIDTH-1:0]   w_step;
  logic [ADDR_WIDTH-1:0]   w_next;
  logic [ADDR_WIDTH-1:0]   w_reg_sum;
  logic [ADDR_WIDTH-1:0]   w_target;

  always_comb begin
    w_cond    = 1'b0;
    w_illegal = 1'b0;
    case (i_operation)
      3'd0:    w_cond = (i_lhs == i_rhs);
      3'd1:    w_cond = (i_lhs != i_rhs);
      3'd4:    w_cond = ($signed(i_lhs) <  $signed(i_rhs));
      3'd5:    w_cond = ($signed(i_lhs) >= $signed(i_rhs));
      3'd6:    w_cond = (i_lhs <  i_rhs);
      3'd7:    w_cond = (i_lhs >= i_rhs);
      default: w_illegal = i_branch;
    endcase
    if (i_register_jump && (i_operation != 3'd0)) begin
      w_illegal = 1'b1;
    end
  end

  assign w_run      = (r_state == S_RUN);
  assign w_step     = (COMPRESSED && i_instr_16) ? ADDR_WIDTH'(2) : ADDR_WIDTH'(4);
  assign w_next     = r_pc + w_step;
  assign w_reg_sum  = i_register_address + i_immediate_offset;
  assign w_target   = i_register_jump ? {w_reg_sum[ADDR_WIDTH-1:1], 1'b0}
                                      : (r_pc + i_immediate_offset);
  assign w_transfer = (i_branch && w_cond) || i_immediate_jump || i_register_jump;

  // Bit 0 is only reachable on PC-relative targets; bit 1 matters without 16-bit support
  assign w_misaligned = w_transfer && (w_target[0] || (!COMPRESSED && w_target[1]));
  assign w_fault      = w_run && (w_illegal || w_misaligned);
  assign w_cause      = w_illegal ? c_CAUSE_ILLEGAL : c_CAUSE_MISALIGN;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_WAIT;
      r_wait_cnt <= c_WAIT_INIT;
    end else begin
      r_state <= w_state_next;
      if ((r_state == S_WAIT) && (r_wait_cnt != 4'd0)) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_WAIT:  if (r_wait_cnt <= 4'd1) w_state_next = S_RUN;
      S_RUN:   if (i_advance && w_fault) w_state_next = S_TRAP;
      S_TRAP:  w_state_next = S_RUN;
      default: w_state_next = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_VECTOR;
      r_epc     <= '0;
      r_cause   <= 2'd0;
      r_instret <= '0;
    end else if (w_run && i_advance) begin
      if (w_fault) begin
        r_pc    <= TRAP_VECTOR;
        r_epc   <= r_pc;
        r_cause <= w_cause;
      end else begin
        r_pc      <= w_transfer ? w_target : w_next;
        r_instret <= r_instret + COUNT_WIDTH'(1);
      end
    end
  end

  assign o_program_count    = r_pc;
  assign o_next_instruction = w_next;
  assign o_fetch_valid      = w_run;
  assign o_redirect         = w_run && i_advance && (w_transfer || w_fault);
  assign o_fault            = w_fault;
  assign o_epc              = r_epc;
  assign o_cause            = r_cause;
  assign o_instret          = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_program_counter.sv
`default_nettype none
// Directed bench: DUT A is 4-byte aligned, DUT B allows 16-bit steps with a wrap-around reset vector.
module tb_program_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst_n_b = 1'b0;
  logic [31:0] lhs = '0, rhs = '0, imm = '0, ra = '0;
  logic [2:0]  op = '0;
  logic        br = 1'b0, ij = 1'b0, rj = 1'b0, i16 = 1'b0, adv = 1'b1;

  logic [31:0] pc_a, nxt_a, epc_a, pc_b, nxt_b, epc_b;
  logic        fv_a, rd_a, flt_a, fv_b, rd_b, flt_b;
  logic [1:0]  cause_a, cause_b;
  logic [63:0] ir_a, ir_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  program_counter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h10),
    .COMPRESSED(1'b0), .WAIT_CYCLES(1), .COUNT_WIDTH(64)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_lhs(lhs), .i_rhs(rhs), .i_operation(op),
    .i_immediate_offset(imm), .i_register_address(ra), .i_branch(br),
    .i_immediate_jump(ij), .i_register_jump(rj), .i_instr_16(i16), .i_advance(adv),
    .o_program_count(pc_a), .o_next_instruction(nxt_a), .o_fetch_valid(fv_a),
    .o_redirect(rd_a), .o_fault(flt_a), .o_epc(epc_a), .o_cause(cause_a), .o_instret(ir_a)
  );

  program_counter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_VECTOR(32'hFFFF_FFFE), .TRAP_VECTOR(32'h10),
    .COMPRESSED(1'b1), .WAIT_CYCLES(0), .COUNT_WIDTH(64)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n_b), .i_lhs(lhs), .i_rhs(rhs), .i_operation(op),
    .i_immediate_offset(imm), .i_register_address(ra), .i_branch(br),
    .i_immediate_jump(ij), .i_register_jump(rj), .i_instr_16(i16), .i_advance(adv),
    .o_program_count(pc_b), .o_next_instruction(nxt_b), .o_fetch_valid(fv_b),
    .o_redirect(rd_b), .o_fault(flt_b), .o_epc(epc_b), .o_cause(cause_b), .o_instret(ir_b)
  );

  task automatic clear_ctl();
    br = 1'b0; ij = 1'b0; rj = 1'b0; i16 = 1'b0; op = 3'd0; imm = '0; ra = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++; if (pc_a !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc_a, 32'h0); end
    n_tests++; if ({fv_a, rd_a, cause_a} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got fv=%b rd=%b cause=%0d want 0", fv_a, rd_a, cause_a); end
    n_tests++; if (epc_a !== 32'h0 || ir_a !== 64'h0) begin n_fail++; $display("FAIL reset_epc_instret: got %h/%0d want 0/0", epc_a, ir_a); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++; if (fv_a !== 1'b0) begin n_fail++; $display("FAIL wait_fetch_valid: got %b want 0", fv_a); end
  endtask

  task automatic test_sequential();
    @(negedge clk);
    n_tests++; if (fv_a !== 1'b1 || pc_a !== 32'h0) begin n_fail++; $display("FAIL run_entry: got fv=%b pc=%h want 1/0", fv_a, pc_a); end
    @(negedge clk);
    n_tests++; if (pc_a !== 32'h4 || ir_a !== 64'd1) begin n_fail++; $display("FAIL seq_step1: got pc=%h ir=%0d want 4/1", pc_a, ir_a); end
    i16 = 1'b1;
    #1;
    n_tests++; if (nxt_a !== 32'h8) begin n_fail++; $display("FAIL instr16_ignored: got %h want %h", nxt_a, 32'h8); end
    @(negedge clk);
    n_tests++; if (pc_a !== 32'h8 || ir_a !== 64'd2) begin n_fail++; $display("FAIL seq_step2: got pc=%h ir=%0d want 8/2", pc_a, ir_a); end
    i16 = 1'b0;
  endtask

  task automatic test_branch();
    ij = 1'b1; imm = 32'h18;
    @(negedge clk);
    n_tests++; if (pc_a !== 32'h20 || ir_a !== 64'd3) begin n_fail++; $display("FAIL imm_jump: got pc=%h ir=%0d want 20/3", pc_a, ir_a); end
    ij = 1'b0; br = 1'b1; op = 3'd4; lhs = 32'hFFFF_FFFF; rhs = 32'h1; imm = 32'hFFFF_FFF8;
    #1;
    n_tests++; if (rd_a !== 1'b1 || flt_a !== 1'b0) begin n_fail++; $display("FAIL blt_redirect: got rd=%b flt=%b want 1/0", rd_a, flt_a); end
    @(negedge clk);
    n_tests++; if (pc_a !== 32'h18 || ir_a !== 64'd4) begin n_fail++; $display("FAIL blt_taken: got pc=%h ir=%0d want 18/4", pc_a, ir_a); end
    br = 1'b0; ij = 1'b1; imm = 32'h8;
    @(negedge clk);
    ij = 1'b0; br = 1'b1; op = 3'd6; imm = 32'hFFFF_FFF8;
    #1;
    n_tests++; if (rd_a !== 1'b0 || nxt_a !== 32'h24) begin n_fail++; $display("FAIL bltu_comb: got rd=%b nxt=%h want 0/24", rd_a, nxt_a); end
    @(negedge clk);
    n_tests++; if (pc_a !== 32'h24 || ir_a !== 64'd6) begin n_fail++; $display("FAIL bltu_not_taken: got pc=%h ir=%0d want 24/6", pc_a, ir_a); end
    clear_ctl();
  endtask

  task automatic test_misaligned();
    rj = 1'b1; op = 3'd0; ra = 32'h103; imm = 32'h0;
    #1;
    n_tests++; if (flt_a !== 1'b1 || rd_a !== 1'b1) begin n_fail++; $display("FAIL misalign_comb: got flt=%b rd=%b want 1/1", flt_a, rd_a); end
    @(negedge clk);
    n_tests++; if (pc_a !== 32'h10 || epc_a !== 32'h24 || cause_a !== 2'd2) begin n_fail++; $display("FAIL misalign_trap: got pc=%h epc=%h cause=%0d want 10/24/2", pc_a, epc_a, cause_a); end
    n_tests++; if (fv_a !== 1'b0 || ir_a !== 64'd6) begin n_fail++; $display("FAIL trap_bubble: got fv=%b ir=%0d want 0/6", fv_a, ir_a); end
    @(negedge clk);
    n_tests++; if (fv_a !== 1'b1 || pc_a !== 32'h10) begin n_fail++; $display("FAIL trap_exit: got fv=%b pc=%h want 1/10", fv_a, pc_a); end
    ra = 32'h3F; imm = 32'h1;
    @(negedge clk);
    n_tests++; if (pc_a !== 32'h40 || ir_a !== 64'd7) begin n_fail++; $display("FAIL jalr_bit0_clear: got pc=%h ir=%0d want 40/7", pc_a, ir_a); end
    clear_ctl();
  endtask

  task automatic test_illegal();
    br = 1'b1; op = 3'd2; lhs = 32'h5; rhs = 32'h5;
    #1;
    n_tests++; if (flt_a !== 1'b1) begin n_fail++; $display("FAIL illegal_comb: got flt=%b want 1", flt_a); end
    @(negedge clk);
    n_tests++; if (pc_a !== 32'h10 || epc_a !== 32'h40 || cause_a !== 2'd1) begin n_fail++; $display("FAIL illegal_trap: got pc=%h epc=%h cause=%0d want 10/40/1", pc_a, epc_a, cause_a); end
    clear_ctl();
    @(negedge clk);
    @(negedge clk);
    n_tests++; if (pc_a !== 32'h14 || ir_a !== 64'd8) begin n_fail++; $display("FAIL post_trap_retire: got pc=%h ir=%0d want 14/8", pc_a, ir_a); end
    n_tests++; if (cause_a !== 2'd1 || epc_a !== 32'h40) begin n_fail++; $display("FAIL cause_persist: got cause=%0d epc=%h want 1/40", cause_a, epc_a); end
  endtask

  task automatic test_stall();
    adv = 1'b0; ij = 1'b1; imm = 32'h100;
    #1;
    n_tests++; if (rd_a !== 1'b0) begin n_fail++; $display("FAIL stall_redirect: got %b want 0", rd_a); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++; if (pc_a !== 32'h14 || ir_a !== 64'd8) begin n_fail++; $display("FAIL stall_hold_%0d: got pc=%h ir=%0d want 14/8", i, pc_a, ir_a); end
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (pc_a !== 32'h0 || ir_a !== 64'd0 || fv_a !== 1'b0) begin n_fail++; $display("FAIL async_reset: got pc=%h ir=%0d fv=%b want 0/0/0", pc_a, ir_a, fv_a); end
    n_tests++; if (cause_a !== 2'd0 || epc_a !== 32'h0) begin n_fail++; $display("FAIL async_reset_cause: got cause=%0d epc=%h want 0/0", cause_a, epc_a); end
    clear_ctl();
    adv = 1'b1;
  endtask

  task automatic test_compressed();
    @(negedge clk);
    i16 = 1'b1;
    rst_n_b = 1'b1;
    #1;
    n_tests++; if (nxt_b !== 32'h0 || fv_b !== 1'b0) begin n_fail++; $display("FAIL c_wrap_next: got nxt=%h fv=%b want 0/0", nxt_b, fv_b); end
    @(negedge clk);
    n_tests++; if (fv_b !== 1'b1 || pc_b !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL c_wait0_run: got fv=%b pc=%h want 1/fffffffe", fv_b, pc_b); end
    ij = 1'b1; imm = 32'h2;
    #1;
    n_tests++; if (flt_b !== 1'b0 || rd_b !== 1'b1) begin n_fail++; $display("FAIL c_jump_comb: got flt=%b rd=%b want 0/1", flt_b, rd_b); end
    @(negedge clk);
    n_tests++; if (pc_b !== 32'h0 || ir_b !== 64'd1) begin n_fail++; $display("FAIL c_jump_wrap: got pc=%h ir=%0d want 0/1", pc_b, ir_b); end
    ij = 1'b0;
    @(negedge clk);
    n_tests++; if (pc_b !== 32'h2) begin n_fail++; $display("FAIL c_step2: got %h want %h", pc_b, 32'h2); end
    ij = 1'b1; imm = 32'h1;
    @(negedge clk);
    n_tests++; if (pc_b !== 32'h10 || cause_b !== 2'd2 || epc_b !== 32'h2) begin n_fail++; $display("FAIL c_odd_target: got pc=%h cause=%0d epc=%h want 10/2/2", pc_b, cause_b, epc_b); end
    clear_ctl();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_misaligned();
    test_illegal();
    test_stall();
    test_compressed();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
